// File: rtl/scroll_pkg.sv
// Shared scroll constants and lane direction encoding.
package scroll_pkg;
  localparam int SCREEN_WIDTH_DEF = 640;
  localparam int TICK_DIV_DEF     = 250000;
  localparam int POS_W_DEF        = 10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/scroll_lane.sv
// One lane: position register with modulo wrap, plus a frame-start shadow when LANE_SCROLLER_FRAME_SYNC_EN is defined.
// Position updates on the edge upd is high; no backpressure.
module scroll_lane
  import scroll_pkg::*;
#(
  parameter int POS_W        = POS_W_DEF,
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int STEP_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              upd,
  input  logic              frame_start,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  output logic [POS_W-1:0]  pos
);

  localparam logic [POS_W:0] SW = (POS_W+1)'(SCREEN_WIDTH);

  logic [POS_W-1:0] live;
  logic [POS_W-1:0] live_nxt;
  logic [POS_W:0]   ext_pos;
  logic [POS_W:0]   ext_step;
  logic [POS_W:0]   sum;

  assign ext_pos  = {1'b0, live};
  assign ext_step = (POS_W+1)'(step);

  // One extra bit keeps pos+step and pos+SW-step from overflowing before the wrap.
  always_comb begin
    sum = ext_pos;
    case (dir)
      DIR_RIGHT: begin
        sum = ext_pos + ext_step;
        if (sum >= SW) sum = sum - SW;
      end
      DIR_LEFT: begin
        if (ext_pos < ext_step) sum = ext_pos + SW - ext_step;
        else                    sum = ext_pos - ext_step;
      end
    endcase
    live_nxt = POS_W'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     live <= '0;
    else if (clear) live <= '0;
    else if (upd)   live <= live_nxt;
  end

`ifdef LANE_SCROLLER_FRAME_SYNC_EN
  logic [POS_W-1:0] shadow;

  // Captures the pre-update value when frame_start coincides with a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           shadow <= '0;
    else if (frame_start) shadow <= clear ? '0 : live;
  end

  assign pos = shadow;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign pos = live;
`endif

endmodule

// File: rtl/lane_scroller.sv
// Multi-lane scroll offsets from one shared tick prescaler; LANE_SCROLLER_FRAME_SYNC_EN enables frame-start latching.
// Lanes move every TICK_DIV enabled cycles, tick is high the cycle after; no backpressure.
module lane_scroller
  import scroll_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int POS_W        = POS_W_DEF,
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int STEP_W       = 3,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int CTR_W        = 18
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          frame_start,
  input  logic [NUM_LANES*STEP_W-1:0]   lane_step,
  input  logic [NUM_LANES-1:0]          lane_dir,
  output logic [NUM_LANES*POS_W-1:0]    lane_pos,
  output logic                          tick
);

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TICK_DIV - 1);

  logic [CTR_W-1:0] ctr;
  logic             tick_edge;
  logic             upd;

  assign tick_edge = enable && (ctr == CTR_LAST);
  assign upd       = tick_edge && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      ctr  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tick_edge;
      if (tick_edge)   ctr <= '0;
      else if (enable) ctr <= ctr + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    scroll_lane #(
      .POS_W        (POS_W),
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .STEP_W       (STEP_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .upd         (upd),
      .frame_start (frame_start),
      .step        (lane_step[i*STEP_W +: STEP_W]),
      .dir         (lane_dir[i]),
      .pos         (lane_pos[i*POS_W +: POS_W])
    );
  end

endmodule
